bsr_bidir_chain: RTL and testbench

- Parametrised boundary scan register for N bidirectional pads. Each pad has three cells: input, output-data and output-enable.
- Holds a capture/shift register and a separate update (hold) register, both clocked on tck with enables from the TAP controller.
- Supports the SAMPLE/PRELOAD, EXTEST and INTEST instructions.
- Sits between the fabric I/O ring and the pads, in series between TAP tdi and tdo when the BSR is the selected data register.

---
 rtl/bsr_bidir_chain.sv | 112 +++++++++++
 tb/tb_bsr_bidir_chain.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_bidir_chain.sv
// bsr_bidir_chain: boundary scan register for N_PINS bidirectional pads.
// Each pad owns three chain cells: input, output-data and output-enable
// (sr[3i], sr[3i+1], sr[3i+2]). A capture/shift register and a separate
// update register are both clocked on tck and enabled by the TAP decode.
// Optional feature macro: BSR_CLAMP_EN adds the clamp (100) and highz (101)
// modes; without it those modes are plain functional pass-through.
// Chain handshake: there is no valid/ready flow here. The TAP strobes
// (captureDR, shiftDR, updateDR) act only when select is high, and each
// strobe is consumed on the rising tck edge on which it is sampled.
module bsr_bidir_chain #(
   parameter int   N_PINS    = 4,
   parameter logic UPD_RESET = 1'b0
) (
   input  logic              tck,
   input  logic              resetn,
   input  logic              select,
   input  logic              captureDR,
   input  logic              shiftDR,
   input  logic              updateDR,
   input  logic [2:0]        mode,
   input  logic              tdi,
   output logic              tdo,
   input  logic [N_PINS-1:0] core_out,
   input  logic [N_PINS-1:0] core_oe,
   output logic [N_PINS-1:0] core_in,
   input  logic [N_PINS-1:0] pad_in,
   output logic [N_PINS-1:0] pad_out,
   output logic [N_PINS-1:0] pad_oe
);

   localparam int L = 3 * N_PINS;

   logic [L-1:0]      sr;
   logic [L-1:0]      ur;
   logic [L-1:0]      cap_vec;
   logic [N_PINS-1:0] ur_in;
   logic [N_PINS-1:0] ur_out;
   logic [N_PINS-1:0] ur_oe;

   // Interleave pad/core signals into chain order for capture, and split the
   // update register back into per-pad input/output/enable vectors.
   always_comb begin
      cap_vec = '0;
      ur_in   = '0;
      ur_out  = '0;
      ur_oe   = '0;
      for (int i = 0; i < N_PINS; i++) begin
         cap_vec[3*i]   = pad_in[i];
         cap_vec[3*i+1] = core_out[i];
         cap_vec[3*i+2] = core_oe[i];
         ur_in[i]       = ur[3*i];
         ur_out[i]      = ur[3*i+1];
         ur_oe[i]       = ur[3*i+2];
      end
   end

   // Capture/shift register: capture wins over shift; tdi enters at bit 0.
   always_ff @(posedge tck) begin
      if (!resetn) begin
         sr <= '0;
      end else if (select) begin
         if (captureDR) begin
            sr <= cap_vec;
         end else if (shiftDR) begin
            sr <= {sr[L-2:0], tdi};
         end
      end
   end

   // Update register latches the pre-edge shift contents, so a shift on the
   // same edge does not disturb what is loaded.
   always_ff @(posedge tck) begin
      if (!resetn) begin
         ur <= {L{UPD_RESET}};
      end else if (select && updateDR) begin
         ur <= sr;
      end
   end

   // tdo is taken straight from the last chain flop.
   assign tdo = sr[L-1];

   // Pad/core steering by instruction mode; unlisted modes are transparent.
   always_comb begin
      pad_out = core_out;
      pad_oe  = core_oe;
      core_in = pad_in;
      case (mode)
         3'b010: begin
            pad_out = ur_out;
            pad_oe  = ur_oe;
         end
         3'b011: begin
            core_in = ur_in;
            pad_out = ur_out;
            pad_oe  = '0;
         end
`ifdef BSR_CLAMP_EN
         3'b100: begin
            pad_out = ur_out;
            pad_oe  = ur_oe;
         end
         3'b101: begin
            pad_oe  = '0;
         end
`endif
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_bsr_bidir_chain.sv
// tb_bsr_bidir_chain: self-checking bench for bsr_bidir_chain (N_PINS=4).
// Expected values are pushed to exp_q when stimulus is applied and popped
// when the DUT output is sampled, 1 time unit after the rising tck edge.
module tb_bsr_bidir_chain;

   localparam int W = 12;

   logic         tck;
   logic         resetn;
   logic         select;
   logic         captureDR;
   logic         shiftDR;
   logic         updateDR;
   logic [2:0]   mode;
   logic         tdi;
   logic         tdo;
   logic [3:0]   core_out;
   logic [3:0]   core_oe;
   logic [3:0]   core_in;
   logic [3:0]   pad_in;
   logic [3:0]   pad_out;
   logic [3:0]   pad_oe;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_errors;

   bsr_bidir_chain #(
      .N_PINS    (4),
      .UPD_RESET (1'b0)
   ) dut (
      .tck       (tck),
      .resetn    (resetn),
      .select    (select),
      .captureDR (captureDR),
      .shiftDR   (shiftDR),
      .updateDR  (updateDR),
      .mode      (mode),
      .tdi       (tdi),
      .tdo       (tdo),
      .core_out  (core_out),
      .core_oe   (core_oe),
      .core_in   (core_in),
      .pad_in    (pad_in),
      .pad_out   (pad_out),
      .pad_oe    (pad_oe)
   );

   // ---------------- clock / reset ----------------
   initial tck = 1'b0;
   always #5 tck = ~tck;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Independent model of the pad/core steering, written from the mode table.
   function automatic logic [11:0] exp_pads(input logic [2:0] m, input logic [11:0] u,
                                            input logic [3:0] co, input logic [3:0] coe,
                                            input logic [3:0] pi);
      logic [3:0] uo, ue, ui, po, pe, ci;
      for (int i = 0; i < 4; i++) begin
         ui[i] = u[3*i];
         uo[i] = u[3*i+1];
         ue[i] = u[3*i+2];
      end
      po = co;
      pe = coe;
      ci = pi;
      if (m == 3'b010) begin
         po = uo; pe = ue;
      end else if (m == 3'b011) begin
         ci = ui; po = uo; pe = 4'h0;
      end
`ifdef BSR_CLAMP_EN
      else if (m == 3'b100) begin
         po = uo; pe = ue;
      end else if (m == 3'b101) begin
         pe = 4'h0;
      end
`endif
      return {po, pe, ci};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge tck);
      #1;
   endtask

   // Drive mode and fabric/pad inputs, queue expected {pad_out,pad_oe,core_in},
   // then sample once the combinational outputs have settled.
   task automatic drive_pads(input string tag, input logic [2:0] m, input logic [3:0] co,
                             input logic [3:0] coe, input logic [3:0] pi,
                             input logic [11:0] exp);
      logic [W-1:0] e;
      mode     = m;
      core_out = co;
      core_oe  = coe;
      pad_in   = pi;
      exp_q.push_back(exp);
      #1;
      e = exp_q.pop_front();
      check(tag, {20'h0, pad_out, pad_oe, core_in}, {20'h0, e});
   endtask

   // Shift v in MSB first so that sr == v afterwards.
   task automatic shift_in(input logic [11:0] v);
      select  = 1'b1;
      shiftDR = 1'b1;
      for (int k = 11; k >= 0; k--) begin
         tdi = v[k];
         step();
      end
      shiftDR = 1'b0;
      tdi     = 1'b0;
   endtask

   task automatic update();
      select   = 1'b1;
      updateDR = 1'b1;
      step();
      updateDR = 1'b0;
   endtask

   // Compare tdo against v[11..0] while shifting zeros in (11 shift edges).
   task automatic shift_out_check(input string tag, input logic [11:0] v);
      logic [W-1:0] e;
      for (int k = 11; k >= 0; k--) exp_q.push_back({11'h0, v[k]});
      select = 1'b1;
      tdi    = 1'b0;
      for (int k = 11; k >= 0; k--) begin
         e = exp_q.pop_front();
         check(tag, {31'h0, tdo}, {31'h0, e[0]});
         if (k > 0) begin
            shiftDR = 1'b1;
            step();
            shiftDR = 1'b0;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [11:0] p;
      logic [11:0] q;
      logic [11:0] r;
      logic [2:0]  rm;
      logic [3:0]  rco, rcoe, rpi;
      n_checks  = 0;
      n_errors  = 0;
      resetn    = 1'b0;
      select    = 1'b0;
      captureDR = 1'b0;
      shiftDR   = 1'b0;
      updateDR  = 1'b0;
      mode      = 3'b000;
      tdi       = 1'b0;
      core_out  = 4'hA;
      core_oe   = 4'hF;
      pad_in    = 4'h5;
      step();
      step();
      check("reset_tdo", {31'h0, tdo}, 32'h0);
      drive_pads("reset_func", 3'b000, 4'hA, 4'hF, 4'h5, {4'hA, 4'hF, 4'h5});
      drive_pads("reset_ur_extest", 3'b010, 4'hA, 4'hF, 4'h5, {4'h0, 4'h0, 4'h5});
      resetn = 1'b1;
      mode   = 3'b000;

      // Capture and shift-out
      select    = 1'b1;
      pad_in    = 4'b0001;
      core_out  = 4'b0000;
      core_oe   = 4'b1000;
      captureDR = 1'b1;
      step();
      captureDR = 1'b0;
      shift_out_check("capture_tdo", 12'b1000_0000_0001);

      // EXTEST drive
      mode = 3'b000;
      shift_in(12'b100_000_000_010);
      update();
      drive_pads("extest", 3'b010, 4'h6, 4'h3, 4'h9, {4'b0001, 4'b1000, 4'h9});

      // INTEST, pad_in changes must not reach core_in
      mode = 3'b000;
      shift_in(12'h001);
      update();
      drive_pads("intest", 3'b011, 4'hF, 4'hF, 4'h0, {4'b0000, 4'b0000, 4'b0001});
      drive_pads("intest_padin", 3'b011, 4'hF, 4'hF, 4'hF, {4'b0000, 4'b0000, 4'b0001});

      // Capture and shift together: capture wins (a shift would give sr[11]=0)
      pad_in    = 4'b0001;
      core_out  = 4'b0000;
      core_oe   = 4'b1000;
      captureDR = 1'b1;
      shiftDR   = 1'b1;
      tdi       = 1'b1;
      step();
      captureDR = 1'b0;
      shiftDR   = 1'b0;
      tdi       = 1'b0;
      shift_out_check("cap_over_shift", 12'b1000_0000_0001);

      // Update and shift together: ur takes pre-edge sr, sr still shifts
      p = 12'hA5C;
      shift_in(p);
      shiftDR  = 1'b1;
      updateDR = 1'b1;
      tdi      = 1'b1;
      step();
      shiftDR  = 1'b0;
      updateDR = 1'b0;
      tdi      = 1'b0;
      drive_pads("upd_shift_extest", 3'b010, 4'h0, 4'h0, 4'h0, exp_pads(3'b010, p, 4'h0, 4'h0, 4'h0));
      drive_pads("upd_shift_intest", 3'b011, 4'h0, 4'h0, 4'h0, exp_pads(3'b011, p, 4'h0, 4'h0, 4'h0));
      shift_out_check("upd_shift_sr", {p[10:0], 1'b1});

      // select=0: shift, capture and update strobes are ignored
      q = 12'h3C9;
      shift_in(q);
      select    = 1'b0;
      shiftDR   = 1'b1;
      updateDR  = 1'b1;
      tdi       = 1'b1;
      for (int k = 0; k < 3; k++) step();
      captureDR = 1'b1;
      step();
      captureDR = 1'b0;
      shiftDR   = 1'b0;
      updateDR  = 1'b0;
      tdi       = 1'b0;
      drive_pads("nosel_ur_hold", 3'b010, 4'h0, 4'h0, 4'h0, exp_pads(3'b010, p, 4'h0, 4'h0, 4'h0));
      shift_out_check("nosel_sr_hold", q);

      // Reset mid-shift with every strobe asserted
      shift_in(12'hFFF);
      update();
      shiftDR = 1'b1;
      tdi     = 1'b1;
      step();
      resetn    = 1'b0;
      captureDR = 1'b1;
      updateDR  = 1'b1;
      step();
      resetn    = 1'b1;
      captureDR = 1'b0;
      updateDR  = 1'b0;
      shiftDR   = 1'b0;
      tdi       = 1'b0;
      drive_pads("midrst_ur", 3'b010, 4'h0, 4'h0, 4'h0, {4'h0, 4'h0, 4'h0});
      shift_out_check("midrst_sr", 12'h000);

      // Clamp / highz / 11x after an extest preload
      mode = 3'b000;
      shift_in(12'b100_000_000_010);
      update();
`ifdef BSR_CLAMP_EN
      drive_pads("clamp", 3'b100, 4'h6, 4'h3, 4'h9, {4'b0001, 4'b1000, 4'h9});
      drive_pads("highz", 3'b101, 4'h6, 4'h3, 4'h9, {4'h6, 4'h0, 4'h9});
`else
      drive_pads("clamp_off", 3'b100, 4'h6, 4'h3, 4'h9, {4'h6, 4'h3, 4'h9});
      drive_pads("highz_off", 3'b101, 4'h6, 4'h3, 4'h9, {4'h6, 4'h3, 4'h9});
`endif
      drive_pads("mode110", 3'b110, 4'h6, 4'h3, 4'h9, {4'h6, 4'h3, 4'h9});
      drive_pads("sample", 3'b001, 4'h6, 4'h3, 4'h9, {4'h6, 4'h3, 4'h9});
      // Mode changes leave the update register intact
      drive_pads("extest_again", 3'b010, 4'h6, 4'h3, 4'h9, {4'b0001, 4'b1000, 4'h9});

      // Random update contents across every mode
      for (int t = 0; t < 6; t++) begin
         r    = 12'($urandom_range(0, 4095));
         mode = 3'b000;
         shift_in(r);
         update();
         for (int m = 0; m < 8; m++) begin
            rm   = 3'(m);
            rco  = 4'($urandom_range(0, 15));
            rcoe = 4'($urandom_range(0, 15));
            rpi  = 4'($urandom_range(0, 15));
            drive_pads("rand_mode", rm, rco, rcoe, rpi, exp_pads(rm, r, rco, rcoe, rpi));
         end
         shift_out_check("rand_sr", r);
      end

      check("sb_empty", exp_q.size(), 32'h0);

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
